rmt_cfg_data_arbiter: RTL and testbench
=======================================

Name: rmt_cfg_data_arbiter

Overview:
Packet-granular arbiter that merges two AXI-Stream sources onto the single slave AXIS input of rmt_wrapper. The two sources are a control-plane stream carrying RMT reconfiguration packets and the data-plane packet stream. Config packets have priority, bounded by a burst limit so data traffic is never starved. A registered output stage feeds rmt_wrapper, and per-source packet counters support debug and verification.

Parameters:
C_S_AXIS_DATA_WIDTH, 512, tdata width of all streams
C_S_AXIS_TUSER_WIDTH, 128, tuser width of all streams
CFG_BURST_MAX, 4, max consecutive config packets granted while data is waiting (>=1)
CNT_WIDTH, 32, packet counter width

Ports:
clk  in  1  single clock for all logic
areset  in  1  asynchronous, active-high reset
s_cfg_tdata  in  C_S_AXIS_DATA_WIDTH  config stream data
s_cfg_tkeep  in  C_S_AXIS_DATA_WIDTH/8  config byte enables
s_cfg_tuser  in  C_S_AXIS_TUSER_WIDTH  config sideband
s_cfg_tvalid  in  1  config beat valid
s_cfg_tlast  in  1  last beat of config packet
s_cfg_tready  out  1  config beat accepted
s_data_tdata  in  C_S_AXIS_DATA_WIDTH  data stream data
s_data_tkeep  in  C_S_AXIS_DATA_WIDTH/8  data byte enables
s_data_tuser  in  C_S_AXIS_TUSER_WIDTH  data sideband
s_data_tvalid  in  1  data beat valid
s_data_tlast  in  1  last beat of data packet
s_data_tready  out  1  data beat accepted
m_axis_tdata  out  C_S_AXIS_DATA_WIDTH  merged stream to rmt_wrapper
m_axis_tkeep  out  C_S_AXIS_DATA_WIDTH/8  merged byte enables
m_axis_tuser  out  C_S_AXIS_TUSER_WIDTH  merged sideband
m_axis_tvalid  out  1  merged beat valid
m_axis_tlast  out  1  merged last beat
m_axis_tready  in  1  rmt_wrapper ready
cfg_pkt_cnt  out  CNT_WIDTH  config packets forwarded
data_pkt_cnt  out  CNT_WIDTH  data packets forwarded

Behaviour:
- Reset (async assert, synchronous-safe release):
  - Outputs: all m_axis_* = 0; s_cfg_tready = s_data_tready = 0.
  - Internal state: counters = 0, state = IDLE, cfg_streak = 0.
- FSM states: IDLE, FWD_CFG, FWD_DATA.
- IDLE arbitration, evaluated in one cycle; no input is ready in IDLE:
  - Grant cfg if s_cfg_tvalid && (!s_data_tvalid || cfg_streak < CFG_BURST_MAX). Go to FWD_CFG.
  - Otherwise grant data if s_data_tvalid. Go to FWD_DATA.
  - Neither valid: stay in IDLE.
  - Both valid with cfg_streak == CFG_BURST_MAX: data wins.
- cfg_streak update:
  - Increments (saturating) on each cfg grant.
  - Clears on each data grant.
  - Clears when IDLE is reached with s_cfg_tvalid low.
- FWD_x: s_x_tready = !m_axis_tvalid || m_axis_tready. The other source's tready = 0.
- Accepted beat: registered into the m_axis_* output stage. Latency is 1 cycle from input handshake to m_axis_tvalid.
- Accepting the beat with tlast=1:
  - Returns FSM to IDLE.
  - Increments the matching counter in the same cycle. Counters wrap at 2^CNT_WIDTH.
- Packets never interleave. A granted source owns the output until its tlast beat is accepted, regardless of the other source's valid.
- Throughput: 1 beat/cycle within a packet; minimum 1 idle arbitration cycle between packets.
- Output stage holds m_axis_* stable while m_axis_tvalid && !m_axis_tready. m_axis_tvalid drops when the held beat is taken and no new beat is accepted in the same cycle.
- tdata, tkeep and tuser pass through bit-exact; tuser is not modified.
- Input tvalid dropping mid-packet: the FSM stays in FWD_x and waits; no timeout.
- Reset mid-packet: the partial packet is abandoned, the output is cleared immediately, and the counter does not increment. Downstream recovery is rmt_wrapper's responsibility.

Decomposition:
- Shared package rmt_arb_pkg:
  - state enum (IDLE/FWD_CFG/FWD_DATA)
  - AXIS beat struct {tdata, tkeep, tuser, tlast} parameterised by the default widths
- One natural sub-module, axis_out_reg: a single-entry valid/ready register stage, reusable elsewhere in the rmt path.

Test Plan:
- Single 2-beat config packet (tkeep 64'hffffffffffffffff, then 64'h00000000000fffff), data idle -> identical 2 beats on m_axis, tlast on beat 2, cfg_pkt_cnt=1, data_pkt_cnt=0.
- cfg and data both valid in the same cycle from reset -> config packet forwarded first, then the data packet. No interleaving; check tlast boundaries and tdata order.
- 6 back-to-back config packets with data continuously valid, CFG_BURST_MAX=4 -> order on m_axis is cfg×4, data×1, cfg×2; cfg_pkt_cnt=6, data_pkt_cnt=1.
- m_axis_tready toggled 1010 during a 3-beat data packet -> m_axis_tdata stable while stalled, no beat lost or duplicated, 3 beats out in order.
- areset pulsed high for 1 cycle during beat 2 of a 3-beat packet -> m_axis_tvalid=0 and both counters 0 in the cycle after assertion. The next full packet is forwarded normally and its counter = 1.
- 1-beat data packet with s_data_tvalid held low for 5 cycles after grant -> FSM stays in FWD_DATA, s_cfg_tready remains 0, beat forwarded when valid returns.

Source files
------------

// File: rtl/rmt_arb_pkg.sv
// Shared types and constants for the config/data arbiter feeding rmt_wrapper.
package rmt_arb_pkg;

  localparam int unsigned DEF_DATA_W = 512;
  localparam int unsigned DEF_USER_W = 128;
  localparam int unsigned DEF_KEEP_W = DEF_DATA_W / 8;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE     = 2'd0;
  localparam state_t ST_FWD_CFG  = 2'd1;
  localparam state_t ST_FWD_DATA = 2'd2;

  // One AXIS beat at the default rmt path widths.
  typedef struct packed {
    logic [DEF_DATA_W-1:0] tdata;
    logic [DEF_KEEP_W-1:0] tkeep;
    logic [DEF_USER_W-1:0] tuser;
    logic                  tlast;
  } axis_beat_t;

  localparam int unsigned BEAT_W = $bits(axis_beat_t);

endpackage

// File: rtl/rmt_cfg_data_arbiter_axis_out_reg.sv
// Single-entry valid/ready register stage; accepts a new beat whenever the held
// one is empty or being taken this cycle.
module axis_out_reg #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid_i,
  output logic             s_ready_c_o,
  input  logic [WIDTH-1:0] s_payload_i,
  output logic             m_valid_o,
  input  logic             m_ready_i,
  output logic [WIDTH-1:0] m_payload_o
);

  logic             valid_q;
  logic             valid_d;
  logic [WIDTH-1:0] payload_q;
  logic [WIDTH-1:0] payload_d;

  assign s_ready_c_o = !valid_q || m_ready_i;
  assign m_valid_o   = valid_q;
  assign m_payload_o = payload_q;

  always_comb begin
    valid_d   = valid_q;
    payload_d = payload_q;
    if (s_valid_i && s_ready_c_o) begin
      valid_d   = 1'b1;
      payload_d = s_payload_i;
    end else if (m_ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      payload_q <= '0;
    end else begin
      valid_q   <= valid_d;
      payload_q <= payload_d;
    end
  end

endmodule

// File: rtl/rmt_cfg_data_arbiter.sv
// Packet-granular arbiter merging the config and data AXIS streams into
// rmt_wrapper; config has priority, limited by a burst cap while data waits.
module rmt_cfg_data_arbiter
  import rmt_arb_pkg::*;
#(
  parameter int unsigned C_S_AXIS_DATA_WIDTH  = 512,
  parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
  parameter int unsigned CFG_BURST_MAX        = 4,
  parameter int unsigned CNT_WIDTH            = 32
) (
  input  logic                                 clk,
  input  logic                                 areset,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_cfg_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_cfg_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_cfg_tuser,
  input  logic                                 s_cfg_tvalid,
  input  logic                                 s_cfg_tlast,
  output logic                                 s_cfg_tready,
  input  logic [C_S_AXIS_DATA_WIDTH-1:0]       s_data_tdata,
  input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]     s_data_tkeep,
  input  logic [C_S_AXIS_TUSER_WIDTH-1:0]      s_data_tuser,
  input  logic                                 s_data_tvalid,
  input  logic                                 s_data_tlast,
  output logic                                 s_data_tready,
  output logic [C_S_AXIS_DATA_WIDTH-1:0]       m_axis_tdata,
  output logic [C_S_AXIS_DATA_WIDTH/8-1:0]     m_axis_tkeep,
  output logic [C_S_AXIS_TUSER_WIDTH-1:0]      m_axis_tuser,
  output logic                                 m_axis_tvalid,
  output logic                                 m_axis_tlast,
  input  logic                                 m_axis_tready,
  output logic [CNT_WIDTH-1:0]                 cfg_pkt_cnt,
  output logic [CNT_WIDTH-1:0]                 data_pkt_cnt
);

  localparam int unsigned KEEP_W   = C_S_AXIS_DATA_WIDTH / 8;
  localparam int unsigned PAY_W    = C_S_AXIS_DATA_WIDTH + KEEP_W + C_S_AXIS_TUSER_WIDTH + 1;
  localparam int unsigned STREAK_W = $clog2(CFG_BURST_MAX + 1);

  state_t                state_q;
  state_t                state_d;
  logic [STREAK_W-1:0]   streak_q;
  logic [STREAK_W-1:0]   streak_d;
  logic [CNT_WIDTH-1:0]  cfg_cnt_q;
  logic [CNT_WIDTH-1:0]  cfg_cnt_d;
  logic [CNT_WIDTH-1:0]  data_cnt_q;
  logic [CNT_WIDTH-1:0]  data_cnt_d;

  logic                  stg_valid;
  logic                  stg_ready_c;
  logic [PAY_W-1:0]      stg_payload;
  logic [PAY_W-1:0]      out_payload;

  // The granted source is muxed into the output stage; the other is ignored.
  always_comb begin
    if (state_q == ST_FWD_CFG) begin
      stg_payload = {s_cfg_tdata, s_cfg_tkeep, s_cfg_tuser, s_cfg_tlast};
    end else begin
      stg_payload = {s_data_tdata, s_data_tkeep, s_data_tuser, s_data_tlast};
    end
    stg_valid = ((state_q == ST_FWD_CFG) && s_cfg_tvalid) ||
                ((state_q == ST_FWD_DATA) && s_data_tvalid);
  end

  // Arbitration, ownership and packet accounting.
  always_comb begin
    state_d       = state_q;
    streak_d      = streak_q;
    cfg_cnt_d     = cfg_cnt_q;
    data_cnt_d    = data_cnt_q;
    s_cfg_tready  = 1'b0;
    s_data_tready = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (s_cfg_tvalid && (!s_data_tvalid || (streak_q < STREAK_W'(CFG_BURST_MAX)))) begin
          state_d = ST_FWD_CFG;
          if (streak_q < STREAK_W'(CFG_BURST_MAX)) begin
            streak_d = streak_q + STREAK_W'(1);
          end
        end else begin
          // Either data is granted or nothing is pending; the streak restarts both ways.
          streak_d = '0;
          if (s_data_tvalid) begin
            state_d = ST_FWD_DATA;
          end
        end
      end
      ST_FWD_CFG: begin
        s_cfg_tready = stg_ready_c;
        if (s_cfg_tvalid && stg_ready_c && s_cfg_tlast) begin
          state_d   = ST_IDLE;
          cfg_cnt_d = cfg_cnt_q + CNT_WIDTH'(1);
        end
      end
      ST_FWD_DATA: begin
        s_data_tready = stg_ready_c;
        if (s_data_tvalid && stg_ready_c && s_data_tlast) begin
          state_d    = ST_IDLE;
          data_cnt_d = data_cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q    <= ST_IDLE;
      streak_q   <= '0;
      cfg_cnt_q  <= '0;
      data_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      streak_q   <= streak_d;
      cfg_cnt_q  <= cfg_cnt_d;
      data_cnt_q <= data_cnt_d;
    end
  end

  axis_out_reg #(
    .WIDTH (PAY_W)
  ) u_out_reg (
    .clk         (clk),
    .rst         (areset),
    .s_valid_i   (stg_valid),
    .s_ready_c_o (stg_ready_c),
    .s_payload_i (stg_payload),
    .m_valid_o   (m_axis_tvalid),
    .m_ready_i   (m_axis_tready),
    .m_payload_o (out_payload)
  );

  assign {m_axis_tdata, m_axis_tkeep, m_axis_tuser, m_axis_tlast} = out_payload;
  assign cfg_pkt_cnt  = cfg_cnt_q;
  assign data_pkt_cnt = data_cnt_q;

endmodule

// File: tb/tb_rmt_cfg_data_arbiter.sv
// Directed bench for rmt_cfg_data_arbiter: packet order, burst cap, backpressure,
// mid-packet reset and source stalls.
module tb_rmt_cfg_data_arbiter;

  localparam int unsigned DW = 512;
  localparam int unsigned KW = DW / 8;
  localparam int unsigned UW = 128;
  localparam int unsigned CW = 32;

  logic          clk;
  logic          areset;
  logic [DW-1:0] s_cfg_tdata;
  logic [KW-1:0] s_cfg_tkeep;
  logic [UW-1:0] s_cfg_tuser;
  logic          s_cfg_tvalid;
  logic          s_cfg_tlast;
  logic          s_cfg_tready;
  logic [DW-1:0] s_data_tdata;
  logic [KW-1:0] s_data_tkeep;
  logic [UW-1:0] s_data_tuser;
  logic          s_data_tvalid;
  logic          s_data_tlast;
  logic          s_data_tready;
  logic [DW-1:0] m_axis_tdata;
  logic [KW-1:0] m_axis_tkeep;
  logic [UW-1:0] m_axis_tuser;
  logic          m_axis_tvalid;
  logic          m_axis_tlast;
  logic          m_axis_tready;
  logic [CW-1:0] cfg_pkt_cnt;
  logic [CW-1:0] data_pkt_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [DW-1:0] q_data [$];
  logic [KW-1:0] q_keep [$];
  logic [UW-1:0] q_user [$];
  logic          q_last [$];

  rmt_cfg_data_arbiter #(
    .C_S_AXIS_DATA_WIDTH  (DW),
    .C_S_AXIS_TUSER_WIDTH (UW),
    .CFG_BURST_MAX        (4),
    .CNT_WIDTH            (CW)
  ) dut (
    .clk           (clk),
    .areset        (areset),
    .s_cfg_tdata   (s_cfg_tdata),
    .s_cfg_tkeep   (s_cfg_tkeep),
    .s_cfg_tuser   (s_cfg_tuser),
    .s_cfg_tvalid  (s_cfg_tvalid),
    .s_cfg_tlast   (s_cfg_tlast),
    .s_cfg_tready  (s_cfg_tready),
    .s_data_tdata  (s_data_tdata),
    .s_data_tkeep  (s_data_tkeep),
    .s_data_tuser  (s_data_tuser),
    .s_data_tvalid (s_data_tvalid),
    .s_data_tlast  (s_data_tlast),
    .s_data_tready (s_data_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .cfg_pkt_cnt   (cfg_pkt_cnt),
    .data_pkt_cnt  (data_pkt_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change #1 after posedge, so a handshake seen at negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!areset && m_axis_tvalid && m_axis_tready) begin
      q_data.push_back(m_axis_tdata);
      q_keep.push_back(m_axis_tkeep);
      q_user.push_back(m_axis_tuser);
      q_last.push_back(m_axis_tlast);
    end
  end

  function automatic logic [DW-1:0] mkdata(input logic [31:0] tag);
    return {16{tag}};
  endfunction

  function automatic logic [UW-1:0] mkuser(input logic [31:0] tag);
    return {4{~tag}};
  endfunction

  task automatic clear_q();
    q_data.delete();
    q_keep.delete();
    q_user.delete();
    q_last.delete();
  endtask

  task automatic do_reset();
    areset = 1'b1;
    @(posedge clk);
    #1 areset = 1'b0;
  endtask

  task automatic drain();
    repeat (5) @(posedge clk);
    #1;
  endtask

  task automatic send_cfg(input int nb, input logic [31:0] tag, input logic [KW-1:0] last_keep);
    int t;
    for (int b = 0; b < nb; b++) begin
      s_cfg_tdata  = mkdata(tag + 32'(b));
      s_cfg_tkeep  = (b == nb - 1) ? last_keep : {KW{1'b1}};
      s_cfg_tuser  = mkuser(tag + 32'(b));
      s_cfg_tlast  = (b == nb - 1);
      s_cfg_tvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!s_cfg_tready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!s_cfg_tready) begin
        n_cmp++;
        n_fail++;
        $display("FAIL cfg_accept_timeout tag=%h beat=%0d got tready=0 need 1", tag, b);
      end
      @(posedge clk);
      #1;
    end
    s_cfg_tvalid = 1'b0;
    s_cfg_tlast  = 1'b0;
  endtask

  task automatic send_data(input int nb, input logic [31:0] tag, input logic [KW-1:0] last_keep);
    int t;
    for (int b = 0; b < nb; b++) begin
      s_data_tdata  = mkdata(tag + 32'(b));
      s_data_tkeep  = (b == nb - 1) ? last_keep : {KW{1'b1}};
      s_data_tuser  = mkuser(tag + 32'(b));
      s_data_tlast  = (b == nb - 1);
      s_data_tvalid = 1'b1;
      t = 0;
      @(negedge clk);
      while (!s_data_tready && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (!s_data_tready) begin
        n_cmp++;
        n_fail++;
        $display("FAIL data_accept_timeout tag=%h beat=%0d got tready=0 need 1", tag, b);
      end
      @(posedge clk);
      #1;
    end
    s_data_tvalid = 1'b0;
    s_data_tlast  = 1'b0;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    m_axis_tready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid got %b need 0", m_axis_tvalid); end
    n_cmp++; if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast got %b need 0", m_axis_tlast); end
    n_cmp++; if (m_axis_tdata !== '0) begin n_fail++; $display("FAIL reset_tdata got %h need 0", m_axis_tdata[31:0]); end
    n_cmp++; if (m_axis_tkeep !== '0) begin n_fail++; $display("FAIL reset_tkeep got %h need 0", m_axis_tkeep); end
    n_cmp++; if (m_axis_tuser !== '0) begin n_fail++; $display("FAIL reset_tuser got %h need 0", m_axis_tuser[31:0]); end
    n_cmp++; if ({s_cfg_tready, s_data_tready} !== 2'b00) begin n_fail++; $display("FAIL reset_tready got %b%b need 00", s_cfg_tready, s_data_tready); end
    n_cmp++; if (cfg_pkt_cnt !== '0 || data_pkt_cnt !== '0) begin n_fail++; $display("FAIL reset_cnt got %0d/%0d need 0/0", cfg_pkt_cnt, data_pkt_cnt); end
    @(posedge clk);
    #1 areset = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if ({s_cfg_tready, s_data_tready, m_axis_tvalid} !== 3'b000) begin n_fail++; $display("FAIL idle_quiet got %b%b%b need 000", s_cfg_tready, s_data_tready, m_axis_tvalid); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_single_cfg();
    logic [KW-1:0] ek;
    clear_q();
    m_axis_tready = 1'b1;
    send_cfg(2, 32'h100, 64'h00000000000fffff);
    drain();
    n_cmp++; if (q_data.size() !== 2) begin n_fail++; $display("FAIL single_beats got %0d need 2", q_data.size()); end
    for (int i = 0; i < 2 && i < q_data.size(); i++) begin
      ek = (i == 1) ? 64'h00000000000fffff : 64'hffffffffffffffff;
      n_cmp++; if (q_data[i] !== mkdata(32'h100 + 32'(i))) begin n_fail++; $display("FAIL single_tdata[%0d] got %h need %h", i, q_data[i][31:0], 32'h100 + 32'(i)); end
      n_cmp++; if (q_keep[i] !== ek) begin n_fail++; $display("FAIL single_tkeep[%0d] got %h need %h", i, q_keep[i], ek); end
      n_cmp++; if (q_user[i] !== mkuser(32'h100 + 32'(i))) begin n_fail++; $display("FAIL single_tuser[%0d] got %h need %h", i, q_user[i][31:0], ~(32'h100 + 32'(i))); end
      n_cmp++; if (q_last[i] !== (i == 1)) begin n_fail++; $display("FAIL single_tlast[%0d] got %b need %b", i, q_last[i], (i == 1)); end
    end
    n_cmp++; if (cfg_pkt_cnt !== 32'd1 || data_pkt_cnt !== 32'd0) begin n_fail++; $display("FAIL single_cnt got %0d/%0d need 1/0", cfg_pkt_cnt, data_pkt_cnt); end
  endtask

  task automatic test_both_valid();
    logic [31:0] exp_tag [5];
    logic        exp_last [5];
    exp_tag  = '{32'h200, 32'h201, 32'h300, 32'h301, 32'h302};
    exp_last = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    clear_q();
    fork
      send_cfg(2, 32'h200, {KW{1'b1}});
      send_data(3, 32'h300, {KW{1'b1}});
    join
    drain();
    n_cmp++; if (q_data.size() !== 5) begin n_fail++; $display("FAIL both_beats got %0d need 5", q_data.size()); end
    for (int i = 0; i < 5 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== mkdata(exp_tag[i]) || q_last[i] !== exp_last[i]) begin
        n_fail++; $display("FAIL both_order[%0d] got %h/%b need %h/%b", i, q_data[i][31:0], q_last[i], exp_tag[i], exp_last[i]);
      end
    end
    n_cmp++; if (cfg_pkt_cnt !== 32'd1 || data_pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL both_cnt got %0d/%0d need 1/1", cfg_pkt_cnt, data_pkt_cnt); end
  endtask

  task automatic test_burst();
    logic [31:0] exp_tag [7];
    exp_tag = '{32'h400, 32'h410, 32'h420, 32'h430, 32'h500, 32'h440, 32'h450};
    do_reset();
    clear_q();
    fork
      begin
        for (int i = 0; i < 6; i++) send_cfg(1, 32'h400 + 32'(i * 16), {KW{1'b1}});
      end
      send_data(1, 32'h500, {KW{1'b1}});
    join
    drain();
    n_cmp++; if (q_data.size() !== 7) begin n_fail++; $display("FAIL burst_beats got %0d need 7", q_data.size()); end
    for (int i = 0; i < 7 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== mkdata(exp_tag[i]) || q_last[i] !== 1'b1) begin
        n_fail++; $display("FAIL burst_order[%0d] got %h/%b need %h/1", i, q_data[i][31:0], q_last[i], exp_tag[i]);
      end
    end
    n_cmp++; if (cfg_pkt_cnt !== 32'd6 || data_pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL burst_cnt got %0d/%0d need 6/1", cfg_pkt_cnt, data_pkt_cnt); end
  endtask

  task automatic test_backpressure();
    logic          held;
    logic          stalled;
    logic [DW-1:0] prev;
    held = 1'b0;
    stalled = 1'b0;
    prev = '0;
    clear_q();
    fork
      send_data(3, 32'h600, {KW{1'b1}});
      begin
        for (int c = 0; c < 12; c++) begin
          m_axis_tready = (c % 2 == 0);
          @(posedge clk);
          #1;
        end
        m_axis_tready = 1'b1;
      end
      begin
        for (int c = 0; c < 14; c++) begin
          @(negedge clk);
          if (held) begin
            n_cmp++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== prev) begin
              n_fail++; $display("FAIL bp_hold got %b/%h need 1/%h", m_axis_tvalid, m_axis_tdata[31:0], prev[31:0]);
            end
          end
          held = m_axis_tvalid && !m_axis_tready;
          if (held) stalled = 1'b1;
          prev = m_axis_tdata;
        end
      end
    join
    drain();
    n_cmp++; if (stalled !== 1'b1) begin n_fail++; $display("FAIL bp_stall_seen got %b need 1", stalled); end
    n_cmp++; if (q_data.size() !== 3) begin n_fail++; $display("FAIL bp_beats got %0d need 3", q_data.size()); end
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== mkdata(32'h600 + 32'(i)) || q_last[i] !== (i == 2)) begin
        n_fail++; $display("FAIL bp_order[%0d] got %h/%b need %h/%b", i, q_data[i][31:0], q_last[i], 32'h600 + 32'(i), (i == 2));
      end
    end
    n_cmp++; if (cfg_pkt_cnt !== 32'd6 || data_pkt_cnt !== 32'd2) begin n_fail++; $display("FAIL bp_cnt got %0d/%0d need 6/2", cfg_pkt_cnt, data_pkt_cnt); end
  endtask

  task automatic test_reset_mid();
    int t;
    clear_q();
    m_axis_tready = 1'b1;
    s_data_tdata  = mkdata(32'h700);
    s_data_tkeep  = {KW{1'b1}};
    s_data_tuser  = mkuser(32'h700);
    s_data_tlast  = 1'b0;
    s_data_tvalid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!s_data_tready && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++; if (s_data_tready !== 1'b1) begin n_fail++; $display("FAIL rm_beat1_accept got %b need 1", s_data_tready); end
    @(posedge clk);
    #1;
    s_data_tdata = mkdata(32'h701);
    s_data_tuser = mkuser(32'h701);
    areset = 1'b1;
    @(negedge clk);
    n_cmp++; if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rm_tvalid got %b need 0", m_axis_tvalid); end
    n_cmp++; if (cfg_pkt_cnt !== '0 || data_pkt_cnt !== '0) begin n_fail++; $display("FAIL rm_cnt_clear got %0d/%0d need 0/0", cfg_pkt_cnt, data_pkt_cnt); end
    n_cmp++; if (s_data_tready !== 1'b0) begin n_fail++; $display("FAIL rm_tready got %b need 0", s_data_tready); end
    @(posedge clk);
    #1;
    areset = 1'b0;
    s_data_tvalid = 1'b0;
    send_data(3, 32'h710, {KW{1'b1}});
    drain();
    n_cmp++; if (q_data.size() !== 3) begin n_fail++; $display("FAIL rm_beats got %0d need 3", q_data.size()); end
    for (int i = 0; i < 3 && i < q_data.size(); i++) begin
      n_cmp++; if (q_data[i] !== mkdata(32'h710 + 32'(i)) || q_last[i] !== (i == 2)) begin
        n_fail++; $display("FAIL rm_order[%0d] got %h/%b need %h/%b", i, q_data[i][31:0], q_last[i], 32'h710 + 32'(i), (i == 2));
      end
    end
    n_cmp++; if (cfg_pkt_cnt !== 32'd0 || data_pkt_cnt !== 32'd1) begin n_fail++; $display("FAIL rm_cnt_after got %0d/%0d need 0/1", cfg_pkt_cnt, data_pkt_cnt); end
  endtask

  task automatic test_valid_gap();
    int t;
    clear_q();
    m_axis_tready = 1'b1;
    s_data_tdata  = mkdata(32'h800);
    s_data_tkeep  = {KW{1'b1}};
    s_data_tuser  = mkuser(32'h800);
    s_data_tlast  = 1'b1;
    s_data_tvalid = 1'b1;
    @(negedge clk);
    n_cmp++; if (s_data_tready !== 1'b0) begin n_fail++; $display("FAIL gap_idle_tready got %b need 0", s_data_tready); end
    @(posedge clk);
    #1;
    s_data_tvalid = 1'b0;
    s_cfg_tdata   = mkdata(32'h900);
    s_cfg_tkeep   = {KW{1'b1}};
    s_cfg_tuser   = mkuser(32'h900);
    s_cfg_tlast   = 1'b1;
    s_cfg_tvalid  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_cmp++; if (s_cfg_tready !== 1'b0 || s_data_tready !== 1'b1) begin
        n_fail++; $display("FAIL gap_hold[%0d] got cfg/data tready %b/%b need 0/1", c, s_cfg_tready, s_data_tready);
      end
    end
    @(posedge clk);
    #1 s_data_tvalid = 1'b1;
    @(negedge clk);
    n_cmp++; if (s_data_tready !== 1'b1) begin n_fail++; $display("FAIL gap_accept got %b need 1", s_data_tready); end
    @(posedge clk);
    #1 s_data_tvalid = 1'b0;
    s_data_tlast = 1'b0;
    t = 0;
    @(negedge clk);
    while (!s_cfg_tready && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++; if (s_cfg_tready !== 1'b1) begin n_fail++; $display("FAIL gap_cfg_accept got %b need 1", s_cfg_tready); end
    @(posedge clk);
    #1 s_cfg_tvalid = 1'b0;
    s_cfg_tlast = 1'b0;
    drain();
    n_cmp++; if (q_data.size() !== 2) begin n_fail++; $display("FAIL gap_beats got %0d need 2", q_data.size()); end
    if (q_data.size() >= 2) begin
      n_cmp++; if (q_data[0] !== mkdata(32'h800) || q_data[1] !== mkdata(32'h900)) begin
        n_fail++; $display("FAIL gap_order got %h,%h need 800,900", q_data[0][31:0], q_data[1][31:0]);
      end
    end
    n_cmp++; if (cfg_pkt_cnt !== 32'd1 || data_pkt_cnt !== 32'd2) begin n_fail++; $display("FAIL gap_cnt got %0d/%0d need 1/2", cfg_pkt_cnt, data_pkt_cnt); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not finish, compared=%0d", n_cmp);
    $fatal(1);
  end

  initial begin
    areset        = 1'b1;
    m_axis_tready = 1'b0;
    s_cfg_tdata   = '0;
    s_cfg_tkeep   = '0;
    s_cfg_tuser   = '0;
    s_cfg_tvalid  = 1'b0;
    s_cfg_tlast   = 1'b0;
    s_data_tdata  = '0;
    s_data_tkeep  = '0;
    s_data_tuser  = '0;
    s_data_tvalid = 1'b0;
    s_data_tlast  = 1'b0;
    test_reset();
    test_single_cfg();
    test_both_valid();
    test_burst();
    test_backpressure();
    test_reset_mid();
    test_valid_gap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
